// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: registered multicycle MIPS control FSM with memory wait handshake, in-block branch resolution and a sticky illegal trap.
module mips_multicycle_ctrl #(
  parameter int MEM_WAIT   = 0,
  parameter bit ENABLE_IMM = 1,
  parameter bit ENABLE_JAL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic [1:0]  mem_to_reg,
  output logic [1:0]  reg_dst,
  output logic        reg_write,
  output logic [1:0]  pc_source,
  output logic [2:0]  alu_op,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        illegal,
  output logic [3:0]  state
);
  localparam logic [3:0] FETCH  = 4'd0,  DECODE = 4'd1,  EXEC_M = 4'd2,  MEM_L = 4'd3;
  localparam logic [3:0] WB_L   = 4'd4,  MEM_S  = 4'd5,  EXEC_R = 4'd6,  WB_R  = 4'd7;
  localparam logic [3:0] EXEC_B = 4'd8,  EXEC_J = 4'd9,  EXEC_I = 4'd10, WB_I  = 4'd11;
  localparam logic [3:0] TRAP   = 4'd15;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [3:0] WAIT = 4'(MEM_WAIT);
  logic [3:0] state_q, state_d, cnt_q, cnt_d;
  logic [5:0] op, fn;
  logic       is_jr, is_jal, is_imm, done;
  logic       unused;
  assign op     = instr[31:26];
  assign fn     = instr[5:0];
  assign unused = ^instr[25:6];
  assign is_jr  = ENABLE_JAL && op == OP_R && fn == 6'b001000;
  assign is_jal = ENABLE_JAL && op == OP_JAL;
  assign is_imm = ENABLE_IMM && (op == 6'b001000 || op == 6'b001010 || op == 6'b001100 || op == 6'b001101);
  assign done   = cnt_q == WAIT && mem_ready;
  assign state  = state_q;
  always_comb begin
    state_d = TRAP;
    case (state_q)
      FETCH:  state_d = done ? DECODE : FETCH;
      DECODE: state_d = op == OP_R ? (is_jr ? EXEC_J : EXEC_R)
                      : (op == OP_LW || op == OP_SW) ? EXEC_M
                      : (op == OP_BEQ || op == OP_BNE) ? EXEC_B
                      : (op == OP_J || is_jal) ? EXEC_J
                      : is_imm ? EXEC_I : TRAP;
      EXEC_M: state_d = op == OP_LW ? MEM_L : op == OP_SW ? MEM_S : TRAP;
      MEM_L:  state_d = done ? WB_L : MEM_L;
      MEM_S:  state_d = done ? FETCH : MEM_S;
      EXEC_R: state_d = WB_R;
      EXEC_I: state_d = WB_I;
      WB_L, WB_R, WB_I, EXEC_B, EXEC_J: state_d = FETCH;
      default: state_d = TRAP;
    endcase
    // Counter restarts whenever the state changes, so each memory state sees it at 0 on entry.
    cnt_d = state_d != state_q ? 4'd0 : cnt_q < WAIT ? cnt_q + 4'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 2'b00;
    reg_dst    = 2'b00;
    reg_write  = 1'b0;
    pc_source  = 2'b00;
    alu_op     = 3'b000;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    illegal    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = done;
        pc_write  = done;
      end
      DECODE: alu_src_b = 2'b11;
      EXEC_M: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_L: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      WB_L: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      MEM_S: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
      end
      WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b011;
      end
      WB_I: reg_write = 1'b1;
      EXEC_B: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b001;
        pc_source = 2'b01;
        pc_write  = zero ^ instr[26];
      end
      EXEC_J: begin
        pc_write   = 1'b1;
        pc_source  = is_jr ? 2'b11 : 2'b10;
        reg_write  = is_jal;
        reg_dst    = is_jal ? 2'b10 : 2'b00;
        mem_to_reg = is_jal ? 2'b10 : 2'b00;
      end
      default: illegal = 1'b1;
    endcase
    if (rst) begin
      {pc_write, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a, illegal} = '0;
      {mem_to_reg, reg_dst, pc_source, alu_src_b} = '0;
      alu_op = 3'b000;
    end
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed checks of the control FSM with three parameter sets sharing one stimulus stream.
module tb_mips_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        rst, zero, mem_ready;
  logic [31:0] instr;
  logic        pc_write [3], iord [3], mem_read [3], mem_write [3], ir_write [3];
  logic        reg_write [3], alu_src_a [3], illegal [3];
  logic [1:0]  mem_to_reg [3], reg_dst [3], pc_source [3], alu_src_b [3];
  logic [2:0]  alu_op [3];
  logic [3:0]  state [3];
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.MEM_WAIT(0), .ENABLE_IMM(1), .ENABLE_JAL(1)) u_dut0 (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write[0]), .iord(iord[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .ir_write(ir_write[0]), .mem_to_reg(mem_to_reg[0]), .reg_dst(reg_dst[0]), .reg_write(reg_write[0]),
    .pc_source(pc_source[0]), .alu_op(alu_op[0]), .alu_src_a(alu_src_a[0]), .alu_src_b(alu_src_b[0]),
    .illegal(illegal[0]), .state(state[0]));
  mips_multicycle_ctrl #(.MEM_WAIT(2), .ENABLE_IMM(1), .ENABLE_JAL(1)) u_dut1 (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write[1]), .iord(iord[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .ir_write(ir_write[1]), .mem_to_reg(mem_to_reg[1]), .reg_dst(reg_dst[1]), .reg_write(reg_write[1]),
    .pc_source(pc_source[1]), .alu_op(alu_op[1]), .alu_src_a(alu_src_a[1]), .alu_src_b(alu_src_b[1]),
    .illegal(illegal[1]), .state(state[1]));
  mips_multicycle_ctrl #(.MEM_WAIT(0), .ENABLE_IMM(1), .ENABLE_JAL(0)) u_dut2 (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write[2]), .iord(iord[2]), .mem_read(mem_read[2]), .mem_write(mem_write[2]),
    .ir_write(ir_write[2]), .mem_to_reg(mem_to_reg[2]), .reg_dst(reg_dst[2]), .reg_write(reg_write[2]),
    .pc_source(pc_source[2]), .alu_op(alu_op[2]), .alu_src_a(alu_src_a[2]), .alu_src_b(alu_src_b[2]),
    .illegal(illegal[2]), .state(state[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; zero = 1'b0; mem_ready = 1'b1; instr = 32'h8C820004;
    tick;
    tick;
    check("rst_state", 32'(state[0]), 0);
    check("rst_mem_read", 32'(mem_read[0]), 0);
    check("rst_pc_write", 32'(pc_write[0]), 0);
    check("rst_alu_src_b", 32'(alu_src_b[0]), 0);
    check("rst_illegal", 32'(illegal[0]), 0);
    rst = 1'b0;
    #1;
    check("fetch_pc_write", 32'(pc_write[0]), 1);
    check("fetch_ir_write", 32'(ir_write[0]), 1);
    check("fetch_mem_read", 32'(mem_read[0]), 1);
    check("fetch_alu_src_b", 32'(alu_src_b[0]), 1);
    tick; check("lw_decode", 32'(state[0]), 1);
    check("decode_alu_src_b", 32'(alu_src_b[0]), 3);
    tick; check("lw_exec_m", 32'(state[0]), 2);
    check("exec_m_srcs", 32'({alu_src_a[0], alu_src_b[0]}), 32'b110);
    tick; check("lw_mem_l", 32'(state[0]), 3);
    check("mem_l_iord_rd", 32'({iord[0], mem_read[0]}), 32'b11);
    tick; check("lw_wb_l", 32'(state[0]), 4);
    check("wb_l_ctl", 32'({reg_write[0], reg_dst[0], mem_to_reg[0]}), 32'b1_00_01);
    tick; check("lw_back_fetch", 32'(state[0]), 0);
    instr = 32'h14820003;
    tick; tick;
    check("bne_exec_b", 32'(state[0]), 8);
    check("bne_z0_pcw", 32'(pc_write[0]), 1);
    check("exec_b_ctl", 32'({pc_source[0], alu_op[0]}), 32'b01_001);
    zero = 1'b1; #1;
    check("bne_z1_pcw", 32'(pc_write[0]), 0);
    tick;
    instr = 32'h10820003;
    tick; tick;
    check("beq_z1_pcw", 32'(pc_write[0]), 1);
    zero = 1'b0; #1;
    check("beq_z0_pcw", 32'(pc_write[0]), 0);
    tick;
    instr = 32'h0C000010;
    tick; tick;
    check("jal_state", 32'(state[0]), 9);
    check("jal_ctl", 32'({pc_write[0], pc_source[0], reg_write[0], reg_dst[0], mem_to_reg[0]}), 32'b1_10_1_10_10);
    check("jal_disabled_trap", 32'(state[2]), 15);
    check("jal_disabled_illegal", 32'(illegal[2]), 1);
    tick;
    instr = 32'h03E00008;
    tick; tick;
    check("jr_state", 32'(state[0]), 9);
    check("jr_ctl", 32'({pc_write[0], pc_source[0], reg_write[0]}), 32'b1_11_0);
    tick;
    instr = 32'h20820004;
    tick; tick;
    check("addi_exec_i", 32'(state[0]), 10);
    check("exec_i_ctl", 32'({alu_op[0], alu_src_b[0]}), 32'b011_10);
    tick;
    check("addi_wb_i", 32'({state[0], reg_write[0], reg_dst[0], mem_to_reg[0]}), 32'b1011_1_00_00);
    tick;
    instr = 32'h00851020;
    tick; tick;
    check("r_exec_r", 32'(state[0]), 6);
    check("exec_r_alu_op", 32'(alu_op[0]), 2);
    rst = 1'b1; #1;
    check("r_rst_no_write", 32'(reg_write[0]), 0);
    tick;
    check("r_rst_fetch", 32'(state[0]), 0);
    check("r_rst_reg_write", 32'(reg_write[0]), 0);
    rst = 1'b0;
    instr = 32'hFC000000;
    #1;
    tick; tick;
    check("bad_op_trap", 32'(state[0]), 15);
    for (int i = 0; i < 10; i++) begin
      check("trap_illegal", 32'(illegal[0]), 1);
      check("trap_strobes", 32'({pc_write[0], mem_read[0], mem_write[0], ir_write[0], reg_write[0]}), 0);
      tick;
    end
    check("trap_held", 32'(state[0]), 15);
    instr = 32'hAC820004; mem_ready = 1'b1;
    do_reset;
    check("trap_cleared", 32'(illegal[0]), 0);
    check("w2_fetch0_pcw", 32'(pc_write[1]), 0);
    tick; check("w2_fetch1_pcw", 32'(pc_write[1]), 0);
    tick; check("w2_fetch2_pcw", 32'({pc_write[1], ir_write[1]}), 32'b11);
    tick; check("w2_decode", 32'(state[1]), 1);
    tick; check("w2_exec_m", 32'(state[1]), 2);
    tick; check("w2_mem_s_c1", 32'({state[1], mem_write[1], iord[1]}), 32'b0101_1_1);
    tick; check("w2_mem_s_c2", 32'({state[1], mem_write[1]}), 32'b0101_1);
    tick; mem_ready = 1'b0; #1;
    check("w2_mem_s_c3", 32'({state[1], mem_write[1]}), 32'b0101_1);
    tick; mem_ready = 1'b1; #1;
    check("w2_mem_s_c4", 32'({state[1], mem_write[1]}), 32'b0101_1);
    tick; check("w2_mem_s_done", 32'(state[1]), 0);
    check("w2_fetch_again_pcw", 32'(pc_write[1]), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
